ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. Sends command bytes to the keyboard on the shared PS/2 lines, for example 0xED set-LEDs, 0xFF reset and 0xF3 typematic. It is the outbound counterpart of the existing ps2 receiver and sits beside it on clk28. It drives the lines open-drain through output-enable signals and tells the receiver to ignore line activity while a host frame is in flight.

Parameters:
CLK_FREQ, 28_000_000, clk28 frequency in Hz.
INHIBIT_CYCLES, CLK_FREQ/10000, clock-inhibit hold time (100 us).
RTS_CYCLES, CLK_FREQ/500000, data-low overlap before clock release (2 us).
FIRST_TIMEOUT, CLK_FREQ/1000*15, maximum wait for the first device falling edge (15 ms).
EDGE_TIMEOUT, CLK_FREQ/1000*2, maximum gap between later device falling edges (2 ms).

Ports:
clk28  in  1  system clock
rst_n  in  1  synchronous active-low reset
tx_data  in  8  byte to send; sampled on accept
tx_valid  in  1  send request
tx_ready  out  1  high in IDLE; accept = tx_valid & tx_ready
tx_done  out  1  1-cycle pulse: frame acknowledged by device
tx_error  out  1  1-cycle pulse: timeout or missing ACK
rx_inhibit  out  1  high whenever state != IDLE
ps2_clk_in  in  1  raw PS/2 clock line (asynchronous)
ps2_dat_in  in  1  raw PS/2 data line (asynchronous)
ps2_clk_oe  out  1  1 = pull clock low
ps2_dat_oe  out  1  1 = pull data low

Behaviour:
Reset and synchronisation
- Reset (rst_n=0 at a clk28 edge), taking effect next cycle: state=IDLE, clk_oe=0, dat_oe=0, done=0, error=0, counters=0. This applies mid-frame too; lines are released immediately.
- Both inputs pass through a 2-FF synchroniser, then a 3-sample majority filter.
- fall = filtered clock 1->0. It is asserted 4 cycles after the raw edge.

State machine
- IDLE: on accept, latch tx_data and parity = ~^tx_data (odd parity), then go to INHIBIT. tx_valid while not ready is ignored.
- INHIBIT: clk_oe=1, dat_oe=0 for INHIBIT_CYCLES cycles, then RTS.
- RTS: clk_oe=1, dat_oe=1 (start bit 0) for RTS_CYCLES cycles, then SEND with bit index n=0 and timer cleared.
- SEND, line drive:
  - clk_oe=0.
  - Start bit stays driven until the first fall.
  - On each fall the next bit is placed on the line by setting dat_oe = ~bit, in the same cycle as fall is seen.
- SEND, bit sequence:
  - falls 1..8 put data[0..7] on the line, LSB first;
  - fall 9 puts the parity bit on the line;
  - fall 10 puts the stop bit on the line (dat_oe=0, released);
  - fall 11 samples filtered data: 0 -> pulse tx_done, 1 -> pulse tx_error. Either way go to RELEASE.
- Timeouts in SEND:
  - The timer resets on every fall.
  - Before fall 1, timer reaching FIRST_TIMEOUT -> tx_error, both oe=0, go to RELEASE.
  - After fall 1, timer reaching EDGE_TIMEOUT -> same handling.
- RELEASE: both oe=0. Wait until filtered clock and data are both 1 for 1 cycle, then IDLE.
- RELEASE also has a timeout: stuck for EDGE_TIMEOUT -> IDLE without any further pulse.

Output and width rules
- tx_done and tx_error are never asserted together; exactly one fires per accepted frame, except when reset intervenes.
- Counters must hold FIRST_TIMEOUT (420000 at default, 19 bits minimum). The bit index is 4 bits.

Test Plan:
- Reset: hold rst_n=0 during SEND -> next cycle clk_oe=0, dat_oe=0, tx_ready=1, no done/error pulse.
- Send 0xED with a device model clocking at 12.5 kHz and ACKing -> clk_oe high for 2800 cycles, then data bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulses once; rx_inhibit high from accept until IDLE.
- Parity check: 0x00 -> parity 1; 0x01 -> parity 0; 0xFF -> parity 1.
- Device model never clocks -> tx_error exactly 420000 cycles after entering SEND; lines released.
- Device stops after fall 5 -> tx_error 56000 cycles after fall 5; device model holds data high at the 11th fall -> tx_error, not tx_done.
- tx_valid held high through a frame -> exactly one frame sent per IDLE visit. A 1-cycle glitch on ps2_clk_in -> no fall counted.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts
// a byte, odd parity and stop bit out on device clock falls and checks the device ACK.
module ps2_host_tx #(
    parameter int unsigned CLK_FREQ       = 28_000_000,
    parameter int unsigned INHIBIT_CYCLES = CLK_FREQ / 10000,
    parameter int unsigned RTS_CYCLES     = CLK_FREQ / 500000,
    parameter int unsigned FIRST_TIMEOUT  = CLK_FREQ / 1000 * 15,
    parameter int unsigned EDGE_TIMEOUT   = CLK_FREQ / 1000 * 2
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned T_A   = (FIRST_TIMEOUT > EDGE_TIMEOUT) ? FIRST_TIMEOUT : EDGE_TIMEOUT;
    localparam int unsigned T_MAX = (T_A > INHIBIT_CYCLES) ? T_A : INHIBIT_CYCLES;
    localparam int unsigned CW    = $clog2(T_MAX + 1);

    localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] RTS_LAST   = CW'(RTS_CYCLES - 1);
    localparam logic [CW-1:0] FIRST_LAST = CW'(FIRST_TIMEOUT - 1);
    localparam logic [CW-1:0] EDGE_LAST  = CW'(EDGE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        RELEASE
    } state_t;

    state_t        state;
    logic [CW-1:0] timer;
    logic [3:0]    bit_idx;
    logic [7:0]    data_q;
    logic          parity_q;

    logic [1:0] clk_sync, dat_sync;
    logic [1:0] clk_hist, dat_hist;
    logic       clk_filt, dat_filt, clk_filt_d;
    logic       fall;

    // Lines idle high, so the filter chain resets to 1 to avoid a false fall.
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            clk_sync   <= '1;
            dat_sync   <= '1;
            clk_hist   <= '1;
            dat_hist   <= '1;
            clk_filt   <= 1'b1;
            dat_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk_in};
            dat_sync   <= {dat_sync[0], ps2_dat_in};
            clk_hist   <= {clk_hist[0], clk_sync[1]};
            dat_hist   <= {dat_hist[0], dat_sync[1]};
            clk_filt   <= (clk_sync[1] & clk_hist[0]) | (clk_sync[1] & clk_hist[1]) |
                          (clk_hist[0] & clk_hist[1]);
            dat_filt   <= (dat_sync[1] & dat_hist[0]) | (dat_sync[1] & dat_hist[1]) |
                          (dat_hist[0] & dat_hist[1]);
            clk_filt_d <= clk_filt;
        end
    end

    assign fall       = clk_filt_d & ~clk_filt;
    assign tx_ready   = (state == IDLE);
    assign rx_inhibit = (state != IDLE);

    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            data_q     <= '0;
            parity_q   <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (tx_valid) begin
                        data_q     <= tx_data;
                        parity_q   <= ~^tx_data;
                        ps2_clk_oe <= 1'b1;
                        ps2_dat_oe <= 1'b0;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (timer == INH_LAST) begin
                        timer      <= '0;
                        ps2_dat_oe <= 1'b1;
                        state      <= RTS;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RTS: begin
                    if (timer == RTS_LAST) begin
                        timer      <= '0;
                        bit_idx    <= '0;
                        ps2_clk_oe <= 1'b0;
                        state      <= SEND;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SEND: begin
                    if (fall) begin
                        timer   <= '0;
                        bit_idx <= bit_idx + 4'd1;
                        if (bit_idx < 4'd8) begin
                            ps2_dat_oe <= ~data_q[bit_idx[2:0]];
                        end else if (bit_idx == 4'd8) begin
                            ps2_dat_oe <= ~parity_q;
                        end else if (bit_idx == 4'd9) begin
                            ps2_dat_oe <= 1'b0;
                        end else begin
                            // 11th fall: device ACK is a low data line
                            tx_done    <= ~dat_filt;
                            tx_error   <= dat_filt;
                            ps2_dat_oe <= 1'b0;
                            state      <= RELEASE;
                        end
                    end else if ((bit_idx == 4'd0 && timer == FIRST_LAST) ||
                                 (bit_idx != 4'd0 && timer == EDGE_LAST)) begin
                        tx_error   <= 1'b1;
                        timer      <= '0;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        state      <= RELEASE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RELEASE: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    if ((clk_filt && dat_filt) || timer == EDGE_LAST) begin
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    timer      <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
